// File: rtl/fpu_dsqrt_resp.sv
// Iterative single-precision fdiv/fsqrt responder: restoring recurrence, one result bit per cycle,
// stalls the IU while iterating and returns result + destination with a one-cycle FPR write strobe.
module fpu_dsqrt_resp #(
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [4:0]  fd,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic [4:0]  cnt,
  output logic [31:0] q,
  output logic [4:0]  qn,
  output logic        qw
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_reg, state_next;

  logic        op_reg, sign_reg, spec_reg;
  logic [4:0]  fd_reg, cnt_reg, qn_reg;
  logic [9:0]  exp_reg;
  logic [27:0] rem_reg;
  logic [23:0] dvs_reg;
  logic [47:0] rad_reg;
  logic [24:0] quo_reg;
  logic [31:0] spec_val_reg, q_reg;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  // Denormals (exponent field 0) are treated as zero
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  logic        spec_hit;
  logic [31:0] spec_val;
  always_comb begin
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (a_nan || (!op && b_nan))                                  spec_val = QNAN;
    else if (op && sa && !a_zero)                                 spec_val = QNAN;
    else if (!op && ((a_zero && b_zero) || (a_inf && b_inf)))     spec_val = QNAN;
    else if (!op && (b_zero || a_inf))                            spec_val = {sa ^ sb, 31'h7F800000};
    else if (!op && (b_inf || a_zero))                            spec_val = {sa ^ sb, 31'd0};
    else if (op && a_zero)                                        spec_val = {sa, 31'd0};
    else if (op && a_inf)                                         spec_val = 32'h7F800000;
    else                                                          spec_hit = 1'b0;
  end

  // Biased result exponents kept as 10-bit two's complement so over/underflow stay visible
  logic [9:0] div_exp, sqrt_unb, sqrt_exp;
  logic       sqrt_odd;
  assign div_exp  = {2'b00, ea} - {2'b00, eb} + 10'd127;
  assign sqrt_unb = {2'b00, ea} - 10'd127;
  assign sqrt_odd = sqrt_unb[0];
  assign sqrt_exp = {sqrt_unb[9], sqrt_unb[9:1]} + 10'd127;

  logic        div_ge, sqrt_ge;
  logic [27:0] div_sel, sqrt_sh, sqrt_trial, rem_n;
  logic [24:0] quo_n;
  always_comb begin
    div_ge     = rem_reg >= {4'd0, dvs_reg};
    div_sel    = div_ge ? (rem_reg - {4'd0, dvs_reg}) : rem_reg;
    sqrt_sh    = {rem_reg[25:0], rad_reg[47:46]};
    sqrt_trial = {2'b00, quo_reg[23:0], 2'b01};
    sqrt_ge    = sqrt_sh >= sqrt_trial;
    rem_n      = op_reg ? (sqrt_ge ? (sqrt_sh - sqrt_trial) : sqrt_sh) : {div_sel[26:0], 1'b0};
    quo_n      = {quo_reg[23:0], op_reg ? sqrt_ge : div_ge};
  end

  // A leading 0 quotient bit (ma < mb) means normalise by one place
  logic [9:0]  fin_exp;
  logic [22:0] fin_man;
  logic [31:0] fin_q;
  always_comb begin
    fin_exp = (!op_reg && !quo_n[24]) ? (exp_reg - 10'd1) : exp_reg;
    fin_man = (op_reg || !quo_n[24]) ? quo_n[22:0] : quo_n[23:1];
    if (fin_exp[9] || fin_exp == 10'd0) fin_q = {sign_reg, 31'd0};
    else if (fin_exp > 10'd254)         fin_q = {sign_reg, 31'h7F7FFFFF};
    else                                fin_q = {sign_reg, fin_exp[7:0], fin_man};
  end

  logic accept, go_early;
  assign accept   = start && (state_reg != BUSY);
  assign go_early = EARLY_SPECIAL && spec_hit;

  always_ff @(posedge clk) begin
    if (clr) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = go_early ? DONE : BUSY;
      BUSY:    if (cnt_reg == 5'd0) state_next = DONE;
      DONE:    state_next = start ? (go_early ? DONE : BUSY) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      op_reg <= 1'b0; sign_reg <= 1'b0; spec_reg <= 1'b0;
      fd_reg <= '0; cnt_reg <= '0; qn_reg <= '0; exp_reg <= '0;
      rem_reg <= '0; dvs_reg <= '0; rad_reg <= '0; quo_reg <= '0;
      spec_val_reg <= '0; q_reg <= '0;
    end else if (accept) begin
      op_reg       <= op;
      fd_reg       <= fd;
      sign_reg     <= op ? 1'b0 : (sa ^ sb);
      exp_reg      <= op ? sqrt_exp : div_exp;
      rem_reg      <= op ? 28'd0 : {4'd0, 1'b1, fa};
      dvs_reg      <= {1'b1, fb};
      rad_reg      <= {(sqrt_odd ? {1'b1, fa, 1'b0} : {1'b0, 1'b1, fa}), 23'd0};
      quo_reg      <= '0;
      spec_reg     <= spec_hit;
      spec_val_reg <= spec_val;
      if (go_early) begin
        cnt_reg <= 5'd0;
        q_reg   <= spec_val;
        qn_reg  <= fd;
      end else begin
        cnt_reg <= op ? 5'd23 : 5'd24;
      end
    end else if (state_reg == BUSY) begin
      rem_reg <= rem_n;
      quo_reg <= quo_n;
      rad_reg <= {rad_reg[45:0], 2'b00};
      if (cnt_reg == 5'd0) begin
        q_reg  <= spec_reg ? spec_val_reg : fin_q;
        qn_reg <= fd_reg;
      end else begin
        cnt_reg <= cnt_reg - 5'd1;
      end
    end
  end

  assign stall = (state_reg == BUSY);
  assign cnt   = stall ? cnt_reg : 5'd0;
  assign qw    = (state_reg == DONE);
  assign q     = q_reg;
  assign qn    = qn_reg;
endmodule

// File: tb/tb_fpu_dsqrt_resp.sv
// Directed bench for fpu_dsqrt_resp: vector table for results/latency plus hand-written
// sequences for busy-time start, back-to-back issue, mid-op reset and the slow-special variant.
module tb_fpu_dsqrt_resp;
  logic        clk = 1'b0;
  logic        clr, start, op;
  logic [4:0]  fd;
  logic [31:0] a, b;
  logic        stall, qw, stall0, qw0;
  logic [4:0]  cnt, qn, cnt0, qn0;
  logic [31:0] q, q0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_dsqrt_resp #(.EARLY_SPECIAL(1'b1)) u_dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .fd(fd), .a(a), .b(b),
    .stall(stall), .cnt(cnt), .q(q), .qn(qn), .qw(qw));

  fpu_dsqrt_resp #(.EARLY_SPECIAL(1'b0)) u_dut0 (
    .clk(clk), .clr(clr), .start(start), .op(op), .fd(fd), .a(a), .b(b),
    .stall(stall0), .cnt(cnt0), .q(q0), .qn(qn0), .qw(qw0));

  typedef struct {
    logic        o;
    logic [4:0]  d;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] eq;
    int          lat;
  } vec_t;

  vec_t        vecs[27];
  logic [31:0] hold_q;
  logic [4:0]  hold_qn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called on a falling edge; issues one op and follows it until qw (or 40 cycles)
  task automatic do_vec(input string tag, input logic o, input logic [4:0] d,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eq, input int el);
    int lat = -1, stalls = 0, cnt_bad = 0, hold_bad = 0, exp_cnt;
    logic [31:0] qv = 32'hx;
    logic [4:0]  qnv = 5'hx;
    start = 1'b1; op = o; fd = d; a = av; b = bv;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (stall) stalls++;
      exp_cnt = (n < el) ? (el - 1 - n) : 0;
      if (cnt !== exp_cnt[4:0]) cnt_bad++;
      if (qw === 1'b1) begin
        lat = n; qv = q; qnv = qn;
        break;
      end
      if (q !== hold_q || qn !== hold_qn) hold_bad++;
    end
    $display("%s op=%0d a=%h b=%h q=%h qn=%0d lat=%0d stalls=%0d", tag, o, av, bv, qv, qnv, lat, stalls);
    chk({tag, " q"}, qv, eq);
    chk({tag, " qn"}, {27'd0, qnv}, {27'd0, d});
    chk({tag, " latency"}, lat, el);
    chk({tag, " stall_cycles"}, stalls, el - 1);
    chk({tag, " cnt_bad_cycles"}, cnt_bad, 0);
    chk({tag, " hold_bad_cycles"}, hold_bad, 0);
    hold_q = eq;
    hold_qn = d;
  endtask

  initial begin
    int lat, stalls, qw_seen;
    logic [31:0] qv;
    logic [4:0]  qnv;

    vecs[0]  = '{1'b0, 5'd3,  32'h40C00000, 32'h40000000, 32'h40400000, 26};
    vecs[1]  = '{1'b1, 5'd7,  32'h41100000, 32'h00000000, 32'h40400000, 25};
    vecs[2]  = '{1'b0, 5'd1,  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26};
    vecs[3]  = '{1'b0, 5'd2,  32'h3F800000, 32'h3F800000, 32'h3F800000, 26};
    vecs[4]  = '{1'b0, 5'd4,  32'h3F800000, 32'h00000000, 32'h7F800000, 1};
    vecs[5]  = '{1'b0, 5'd5,  32'hBF800000, 32'h00000000, 32'hFF800000, 1};
    vecs[6]  = '{1'b1, 5'd6,  32'hC0800000, 32'h00000000, 32'h7FC00000, 1};
    vecs[7]  = '{1'b0, 5'd8,  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1};
    vecs[8]  = '{1'b0, 5'd9,  32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 26};
    vecs[9]  = '{1'b0, 5'd10, 32'h00800000, 32'h41000000, 32'h00000000, 26};
    vecs[10] = '{1'b1, 5'd11, 32'h40800000, 32'h00000000, 32'h40000000, 25};
    vecs[11] = '{1'b1, 5'd12, 32'h40000000, 32'h00000000, 32'h3FB504F3, 25};
    vecs[12] = '{1'b1, 5'd13, 32'h3F000000, 32'h00000000, 32'h3F3504F3, 25};
    vecs[13] = '{1'b1, 5'd14, 32'h3E800000, 32'h00000000, 32'h3F000000, 25};
    vecs[14] = '{1'b0, 5'd15, 32'h40C00000, 32'hC0000000, 32'hC0400000, 26};
    vecs[15] = '{1'b0, 5'd16, 32'h00000000, 32'h40A00000, 32'h00000000, 1};
    vecs[16] = '{1'b0, 5'd17, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1};
    vecs[17] = '{1'b0, 5'd18, 32'h40000000, 32'h7F800000, 32'h00000000, 1};
    vecs[18] = '{1'b0, 5'd19, 32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    vecs[19] = '{1'b1, 5'd20, 32'h7F800000, 32'h00000000, 32'h7F800000, 1};
    vecs[20] = '{1'b1, 5'd21, 32'h80000000, 32'h00000000, 32'h80000000, 1};
    vecs[21] = '{1'b0, 5'd22, 32'h00000001, 32'h3F800000, 32'h00000000, 1};
    vecs[22] = '{1'b0, 5'd23, 32'h00000000, 32'h00000000, 32'h7FC00000, 1};
    vecs[23] = '{1'b0, 5'd24, 32'h00800000, 32'h3F800000, 32'h00800000, 26};
    vecs[24] = '{1'b0, 5'd25, 32'h00800000, 32'h3FC00000, 32'h00000000, 26};
    vecs[25] = '{1'b0, 5'd26, 32'hFF000000, 32'h3F000000, 32'hFF7FFFFF, 26};
    vecs[26] = '{1'b0, 5'd27, 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 26};

    clr = 1'b1; start = 1'b0; op = 1'b0; fd = 5'd0; a = 32'd0; b = 32'd0;
    hold_q = 32'd0; hold_qn = 5'd0;
    repeat (3) @(negedge clk);
    start = 1'b1;  // reset must override start
    @(negedge clk);
    start = 1'b0;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset cnt", {27'd0, cnt}, 32'd0);
    chk("reset q", q, 32'd0);
    chk("reset qn", {27'd0, qn}, 32'd0);
    chk("reset qw", {31'd0, qw}, 32'd0);
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 27; i++) begin
      do_vec($sformatf("vec%0d", i), vecs[i].o, vecs[i].d, vecs[i].av, vecs[i].bv, vecs[i].eq, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d qw_one_cycle", i), {31'd0, qw}, 32'd0);
      chk($sformatf("vec%0d idle_after", i), {31'd0, stall}, 32'd0);
    end

    // Back-to-back: second op issued in the DONE cycle of the first
    do_vec("b2b_first", 1'b0, 5'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 26);
    do_vec("b2b_second", 1'b0, 5'd5, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26);
    @(negedge clk);

    // start held/changed while BUSY must be ignored
    start = 1'b1; op = 1'b0; fd = 5'd3; a = 32'h40C00000; b = 32'h40000000;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin op = 1'b1; fd = 5'd9; a = 32'h41100000; end
      if (n == 10) start = 1'b0;
      if (qw === 1'b1) begin lat = n; qv = q; qnv = qn; break; end
    end
    $display("busy_start lat=%0d q=%h qn=%0d", lat, qv, qnv);
    chk("busy_start latency", lat, 26);
    chk("busy_start q", qv, 32'h40400000);
    chk("busy_start qn", {27'd0, qnv}, 32'd3);
    @(negedge clk);
    chk("busy_start no_second_op", {31'd0, stall | qw}, 32'd0);

    // clr ten cycles into a divide aborts it with no write strobe
    start = 1'b1; op = 1'b0; fd = 5'd3; a = 32'h40C00000; b = 32'h40000000;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort q", q, 32'd0);
    qw_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (qw === 1'b1) qw_seen++;
    end
    $display("abort qw_seen=%0d", qw_seen);
    chk("abort qw_never", qw_seen, 0);
    hold_q = 32'd0; hold_qn = 5'd0;
    do_vec("after_abort", 1'b0, 5'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 26);
    @(negedge clk);

    // Slow-special variant: 1/0 runs the full divide count
    start = 1'b1; op = 1'b0; fd = 5'd12; a = 32'h3F800000; b = 32'h00000000;
    lat = -1; stalls = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (stall0) stalls++;
      if (qw0 === 1'b1) begin lat = n; qv = q0; qnv = qn0; break; end
    end
    $display("slow_special lat=%0d stalls=%0d q=%h qn=%0d", lat, stalls, qv, qnv);
    chk("slow_special latency", lat, 26);
    chk("slow_special stalls", stalls, 25);
    chk("slow_special q", qv, 32'h7F800000);
    chk("slow_special qn", {27'd0, qnv}, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
